// File: rtl/c7bexu_ifu_fetch.sv
// Instruction fetch front end: sequential PC generation, single-outstanding
// fetch requests, a 2-entry fetch queue toward decode, and redirect flush.
module c7bexu_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ifu,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  output logic        icu_req,
  output logic [31:0] icu_addr,
  input  logic        icu_gnt,
  input  logic        icu_rvld,
  input  logic [31:0] icu_rdata,
  output logic        ifu_inst_vld_d,
  output logic [31:0] ifu_inst_d,
  output logic [31:0] ifu_pc_d
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        drop;

  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];

  logic [31:0] tgt;
  logic [31:0] pc_nxt;
  logic        push;
  logic        pop;
  logic [1:0]  count_nxt;
  logic        credit;

  assign tgt            = {br_target[31:2], 2'b00};
  assign pc_nxt         = br_redirect ? tgt : fetch_pc;
  assign ifu_inst_vld_d = (count != 2'd0) & ~stall_ifu & ~br_redirect;
  assign pop            = ifu_inst_vld_d;
  // A response that races a redirect, or belongs to a dropped request, never enters the queue.
  assign push           = (state == WAIT) & icu_rvld & ~drop & ~br_redirect;
  assign ifu_inst_d     = q_inst[rd_ptr];
  assign ifu_pc_d       = q_pc[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (br_redirect) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end
  end

  // Credit counts queue occupancy after this edge plus a request still in flight.
  assign credit = ({1'b0, count_nxt} + {2'b00, outstanding & ~icu_rvld}) < 3'd2;

  // Request FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      icu_req     <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (br_redirect)
        fetch_pc <= tgt;
      case (state)
        IDLE: begin
          if (!br_redirect && credit) begin
            state   <= REQ;
            icu_req <= 1'b1;
          end
        end
        REQ: begin
          if (icu_gnt) begin
            state       <= WAIT;
            icu_req     <= 1'b0;
            outstanding <= 1'b1;
            drop        <= drop | br_redirect;
            // A stale request must not advance the PC that already holds the target.
            if (!br_redirect && !drop)
              fetch_pc <= fetch_pc + PC_INC;
          end else if (br_redirect) begin
            drop <= 1'b1;
          end
        end
        WAIT: begin
          if (icu_rvld) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
            if (credit) begin
              state   <= REQ;
              icu_req <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (br_redirect) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          icu_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state == IDLE && !br_redirect && credit) ||
        (state == WAIT && icu_rvld && credit))
      icu_addr <= pc_nxt;
    if (state == REQ && icu_gnt)
      req_pc <= icu_addr;
  end

  // Fetch queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count_nxt;
      if (br_redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= ~wr_ptr;
        if (pop)
          rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= icu_rdata;
    end
  end

  a_no_push_on_full: assert property (@(posedge clk) disable iff (reset)
    !(push && count == 2'd2));

endmodule

// File: tb/tb_c7bexu_ifu_fetch.sv
// Directed bench for c7bexu_ifu_fetch with a single-outstanding memory model
// whose grant and response timing are steered by the stimulus.
module tb_c7bexu_ifu_fetch;

  logic        clk;
  logic        reset;
  logic        stall_ifu;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        icu_req;
  logic [31:0] icu_addr;
  logic        icu_gnt;
  logic        icu_rvld;
  logic [31:0] icu_rdata;
  logic        ifu_inst_vld_d;
  logic [31:0] ifu_inst_d;
  logic [31:0] ifu_pc_d;

  logic        gnt_en;
  logic        rsp_en;
  logic        pend;
  logic [31:0] pend_addr;
  int          n_gnt;
  int          n_tests;
  int          n_fail;

  c7bexu_ifu_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall_ifu      (stall_ifu),
    .br_redirect    (br_redirect),
    .br_target      (br_target),
    .icu_req        (icu_req),
    .icu_addr       (icu_addr),
    .icu_gnt        (icu_gnt),
    .icu_rvld       (icu_rvld),
    .icu_rdata      (icu_rdata),
    .ifu_inst_vld_d (ifu_inst_vld_d),
    .ifu_inst_d     (ifu_inst_d),
    .ifu_pc_d       (ifu_pc_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Memory model: grant when enabled, respond in the cycle after the grant (or later).
  always @(negedge clk) begin
    if (reset) begin
      pend      = 1'b0;
      pend_addr = 32'h0;
      n_gnt     = 0;
      icu_rvld  = 1'b0;
      icu_gnt   = 1'b0;
      icu_rdata = 32'h0;
    end else begin
      icu_rvld = 1'b0;
      if (pend && rsp_en) begin
        icu_rvld  = 1'b1;
        icu_rdata = inst_of(pend_addr);
        pend      = 1'b0;
      end
      icu_gnt = gnt_en;
      if (icu_req && icu_gnt) begin
        pend      = 1'b1;
        pend_addr = icu_addr;
        n_gnt     = n_gnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic g, input logic r, input logic s);
    reset       = 1'b1;
    gnt_en      = g;
    rsp_en      = r;
    stall_ifu   = s;
    br_redirect = 1'b0;
    br_target   = 32'h0;
    #1;
    chk("rst_req", {31'h0, icu_req}, 32'h0);
    chk("rst_vld", {31'h0, ifu_inst_vld_d}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_vld(input string tag, output logic [31:0] pc, output logic [31:0] inst);
    logic found;
    found = 1'b0;
    pc    = 32'hx;
    inst  = 32'hx;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifu_inst_vld_d) begin
        found = 1'b1;
        pc    = ifu_pc_d;
        inst  = ifu_inst_d;
        break;
      end
    end
    if (!found)
      chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] inst;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    gnt_en      = 1'b0;
    rsp_en      = 1'b0;
    stall_ifu   = 1'b0;
    br_redirect = 1'b0;
    br_target   = 32'h0;

    // Streaming fetch
    do_reset(1'b1, 1'b1, 1'b0);
    tick();
    chk("s_req1", {31'h0, icu_req}, 32'h1);
    chk("s_addr1", icu_addr, 32'h1c000000);
    chk("s_vld1", {31'h0, ifu_inst_vld_d}, 32'h0);
    tick();
    chk("s_req2", {31'h0, icu_req}, 32'h0);
    chk("s_vld2", {31'h0, ifu_inst_vld_d}, 32'h0);
    tick();
    chk("s_vld3", {31'h0, ifu_inst_vld_d}, 32'h1);
    chk("s_pc3", ifu_pc_d, 32'h1c000000);
    chk("s_inst3", ifu_inst_d, inst_of(32'h1c000000));
    chk("s_addr3", icu_addr, 32'h1c000004);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s_gap_vld", {31'h0, ifu_inst_vld_d}, 32'h0);
      tick();
      chk("s_vld", {31'h0, ifu_inst_vld_d}, 32'h1);
      chk("s_pc", ifu_pc_d, 32'h1c000000 + 32'(4 * k));
      chk("s_inst", ifu_inst_d, inst_of(32'h1c000000 + 32'(4 * k)));
      chk("s_req", {31'h0, icu_req}, 32'h1);
      chk("s_addr", icu_addr, 32'h1c000000 + 32'(4 * (k + 1)));
    end

    // Decode stalled: queue fills with two entries, then fetching stops
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    chk("st_ngnt", 32'(n_gnt), 32'd2);
    chk("st_req", {31'h0, icu_req}, 32'h0);
    chk("st_vld", {31'h0, ifu_inst_vld_d}, 32'h0);
    stall_ifu = 1'b0;
    #1;
    chk("st_vld_a", {31'h0, ifu_inst_vld_d}, 32'h1);
    chk("st_pc_a", ifu_pc_d, 32'h1c000000);
    tick();
    chk("st_vld_b", {31'h0, ifu_inst_vld_d}, 32'h1);
    chk("st_pc_b", ifu_pc_d, 32'h1c000004);
    chk("st_req_b", {31'h0, icu_req}, 32'h1);
    chk("st_addr_b", icu_addr, 32'h1c000008);
    wait_vld("st_c", pc, inst);
    chk("st_pc_c", pc, 32'h1c000008);

    // Redirect while waiting; the late response must be dropped
    do_reset(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    br_redirect = 1'b1;
    br_target   = 32'h00002000;
    tick();
    br_redirect = 1'b0;
    rsp_en      = 1'b1;
    chk("rw_req", {31'h0, icu_req}, 32'h0);
    chk("rw_vld", {31'h0, ifu_inst_vld_d}, 32'h0);
    tick();
    chk("rw_req2", {31'h0, icu_req}, 32'h1);
    chk("rw_addr2", icu_addr, 32'h00002000);
    chk("rw_vld2", {31'h0, ifu_inst_vld_d}, 32'h0);
    wait_vld("rw", pc, inst);
    chk("rw_pc", pc, 32'h00002000);
    chk("rw_inst", inst, inst_of(32'h00002000));

    // Redirect while a request is waiting for grant
    do_reset(1'b0, 1'b1, 1'b0);
    tick();
    br_redirect = 1'b1;
    br_target   = 32'h00003000;
    for (int k = 0; k < 3; k++) begin
      tick();
      br_redirect = 1'b0;
      chk("rq_req_hold", {31'h0, icu_req}, 32'h1);
      chk("rq_addr_hold", icu_addr, 32'h1c000000);
    end
    gnt_en = 1'b1;
    tick();
    chk("rq_req_w", {31'h0, icu_req}, 32'h0);
    tick();
    chk("rq_req_n", {31'h0, icu_req}, 32'h1);
    chk("rq_addr_n", icu_addr, 32'h00003000);
    chk("rq_vld_n", {31'h0, ifu_inst_vld_d}, 32'h0);
    wait_vld("rq", pc, inst);
    chk("rq_pc", pc, 32'h00003000);
    chk("rq_addr_next", icu_addr, 32'h00003004);

    // Redirect, stall and response in the same cycle with one queued entry
    do_reset(1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    br_redirect = 1'b1;
    br_target   = 32'h00004000;
    #1;
    chk("rs_vld_same", {31'h0, ifu_inst_vld_d}, 32'h0);
    tick();
    br_redirect = 1'b0;
    stall_ifu   = 1'b0;
    #1;
    chk("rs_vld_next", {31'h0, ifu_inst_vld_d}, 32'h0);
    chk("rs_req", {31'h0, icu_req}, 32'h1);
    chk("rs_addr", icu_addr, 32'h00004000);
    wait_vld("rs", pc, inst);
    chk("rs_pc", pc, 32'h00004000);

    // Redirect near the top of the address space wraps to zero
    do_reset(1'b1, 1'b1, 1'b0);
    br_redirect = 1'b1;
    br_target   = 32'hfffffffe;
    tick();
    br_redirect = 1'b0;
    chk("wr_req_idle", {31'h0, icu_req}, 32'h0);
    tick();
    chk("wr_req", {31'h0, icu_req}, 32'h1);
    chk("wr_addr", icu_addr, 32'hfffffffc);
    tick();
    tick();
    chk("wr_vld", {31'h0, ifu_inst_vld_d}, 32'h1);
    chk("wr_pc", ifu_pc_d, 32'hfffffffc);
    chk("wr_addr_wrap", icu_addr, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
